// File: rtl/heu_pkg.sv
// Shared types and constants for the HEU window receiver: window buffer layout, tag struct,
// and the pyramid level dimensions used by the position tracker.
package heu_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int BUF_ROWS   = 5;
    localparam int BUF_COLS   = 80;
    localparam int WIN_DIM    = 20;
    localparam int NUM_LEVELS = 6;
    localparam int SUM_W      = 17;

    localparam int LEVEL_DIM [NUM_LEVELS] = '{300, 240, 180, 120, 60, 20};

    typedef logic [BUF_ROWS-1:0][BUF_COLS-1:0][DATA_WIDTH-1:0] win_buf_t;
    typedef logic [WIN_DIM-1:0][DATA_WIDTH-1:0]                win_row_t;

    typedef struct packed {
        logic [2:0] level;
        logic [4:0] row;
        logic [4:0] col;
    } win_tag_t;

    // Highest row/col index of a level: n-1 where n = LEVEL_DIM/10 - 1.
    function automatic logic [4:0] last_idx(input logic [2:0] level);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            if (level == 3'(i)) r = 5'(LEVEL_DIM[i] / 10 - 2);
        end
        return r;
    endfunction

endpackage

// File: rtl/heu_win_rx_if.sv
// Window handshake from IPGU plus the row-beat stream toward HEU compute.
// slave = the receiver, master = the IPGU/compute side.
interface heu_win_rx_if;
    import heu_pkg::*;

    logic             initIpgu;
    logic             vldIpgu;
    win_buf_t         ipguOutBufferQ;
    logic             rdyHeu;
    win_row_t         pix_out;
    logic             pix_vld;
    logic             pix_rdy;
    logic [4:0]       pix_row;
    logic             pix_last;
    logic [2:0]       win_level;
    logic [4:0]       win_row;
    logic [4:0]       win_col;
    logic             frame_done;
    logic [SUM_W-1:0] win_sum;

    modport slave (
        input  initIpgu, vldIpgu, ipguOutBufferQ, pix_rdy,
        output rdyHeu, pix_out, pix_vld, pix_row, pix_last,
               win_level, win_row, win_col, frame_done, win_sum
    );

    modport master (
        output initIpgu, vldIpgu, ipguOutBufferQ, pix_rdy,
        input  rdyHeu, pix_out, pix_vld, pix_row, pix_last,
               win_level, win_row, win_col, frame_done, win_sum
    );

endinterface

// File: rtl/heu_win_tracker.sv
// Pyramid level/row/col position of the next accepted window; pulses frame_done the cycle
// after the final window of the final level is accepted.
module heu_win_tracker
    import heu_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     advance,
    input  logic     clear,
    output win_tag_t tag,
    output logic     frame_done
);

    logic [4:0] last;
    logic       col_wrap;
    logic       row_wrap;
    logic       lvl_wrap;

    assign last     = last_idx(tag.level);
    assign col_wrap = (tag.col == last);
    assign row_wrap = (tag.row == last);
    assign lvl_wrap = (tag.level == 3'(NUM_LEVELS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag        <= '0;
            frame_done <= 1'b0;
        end else if (clear) begin
            tag        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= advance && col_wrap && row_wrap && lvl_wrap;
            if (advance) begin
                if (!col_wrap) begin
                    tag.col <= tag.col + 5'd1;
                end else begin
                    tag.col <= '0;
                    if (!row_wrap) begin
                        tag.row <= tag.row + 5'd1;
                    end else begin
                        tag.row   <= '0;
                        tag.level <= lvl_wrap ? 3'd0 : tag.level + 3'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/heu_win_rx.sv
// HEU window receiver: 2-entry ping-pong buffer of IPGU windows streamed out as 20 row beats.
// Optional feature macro HEU_WIN_SUM_EN adds a per-window pixel sum on win_sum.
module heu_win_rx
    import heu_pkg::*;
(
    input logic          clk,
    input logic          rst_n,
    heu_win_rx_if.slave  bus
);

    localparam logic [4:0] LAST_BEAT = 5'(WIN_DIM - 1);

    win_buf_t   buf_q [2];
    win_tag_t   tag_q [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic [1:0] count_next;
    logic [4:0] beat;
    logic       accept;
    logic       xfer;
    logic       pop;
    win_tag_t   cur_tag;

    logic [BUF_COLS-1:0][DATA_WIDTH-1:0] buf_row;
    logic [6:0]                          base;
    win_row_t                            row_sel;

    assign accept = bus.vldIpgu && bus.rdyHeu && !bus.initIpgu;
    assign xfer   = bus.pix_vld && bus.pix_rdy && !bus.initIpgu;
    assign pop    = xfer && (beat == LAST_BEAT);

    always_comb begin
        count_next = count;
        if (bus.initIpgu) count_next = '0;
        else              count_next = count + 2'(accept) - 2'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            beat       <= '0;
            bus.rdyHeu <= 1'b0;
        end else begin
            count      <= count_next;
            // Registered ready: a pop this cycle only frees a slot from the next cycle on.
            bus.rdyHeu <= (count_next < 2'd2) && !bus.initIpgu;
            if (bus.initIpgu) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
                beat   <= '0;
            end else begin
                if (accept) wr_ptr <= ~wr_ptr;
                if (pop)    rd_ptr <= ~rd_ptr;
                if (xfer)   beat   <= pop ? 5'd0 : beat + 5'd1;
            end
        end
    end

    // Window payload storage carries no reset; outputs are gated by pix_vld instead.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_q[wr_ptr] <= bus.ipguOutBufferQ;
            tag_q[wr_ptr] <= cur_tag;
        end
    end

    heu_win_tracker u_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance    (accept),
        .clear      (bus.initIpgu),
        .tag        (cur_tag),
        .frame_done (bus.frame_done)
    );

    // Window row r lives in buffer row r/4, pixels (r%4)*20 onward.
    assign buf_row = buf_q[rd_ptr][beat[4:2]];
    assign base    = 7'(beat[1:0]) * 7'd20;
    assign row_sel = buf_row[base +: WIN_DIM];

    assign bus.pix_vld   = (count != 2'd0);
    assign bus.pix_out   = bus.pix_vld ? row_sel : '0;
    assign bus.pix_row   = beat;
    assign bus.pix_last  = bus.pix_vld && (beat == LAST_BEAT);
    assign bus.win_level = bus.pix_vld ? tag_q[rd_ptr].level : '0;
    assign bus.win_row   = bus.pix_vld ? tag_q[rd_ptr].row   : '0;
    assign bus.win_col   = bus.pix_vld ? tag_q[rd_ptr].col   : '0;

`ifdef HEU_WIN_SUM_EN
    function automatic logic [SUM_W-1:0] row_sum(input win_row_t r);
        logic [SUM_W-1:0] s;
        s = '0;
        for (int k = 0; k < WIN_DIM; k++) s = s + SUM_W'(r[k]);
        return s;
    endfunction

    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] beat_sum;

    assign beat_sum = row_sum(bus.pix_out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    acc <= '0;
        else if (bus.initIpgu || pop)  acc <= '0;
        else if (xfer)                 acc <= acc + beat_sum;
    end

    assign bus.win_sum = bus.pix_last ? acc + beat_sum : '0;
`else
    assign bus.win_sum = '0;
`endif

endmodule

// File: tb/tb_heu_win_rx.sv
// Directed-plus-random bench for heu_win_rx against a queue/arithmetic reference model.
// Honours HEU_WIN_SUM_EN for the expected win_sum.
module tb_heu_win_rx;
    import heu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    heu_win_rx_if bus();

    heu_win_rx dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_row(input string tag, input win_row_t obs, input win_row_t exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: tag of the idx-th window after start of image, from level sizes n*n.
    function automatic win_tag_t tag_of(input int idx);
        int n [6] = '{29, 23, 17, 11, 5, 1};
        int rem;
        win_tag_t t;
        rem = idx % 1806;
        t = '0;
        for (int l = 0; l < 6; l++) begin
            if (rem >= 0 && rem < n[l] * n[l]) begin
                t.level = 3'(l);
                t.row   = 5'(rem / n[l]);
                t.col   = 5'(rem % n[l]);
            end
            rem = rem - n[l] * n[l];
        end
        return t;
    endfunction

    function automatic win_buf_t rand_win();
        win_buf_t w;
        for (int i = 0; i < BUF_ROWS; i++)
            for (int j = 0; j < BUF_COLS; j++)
                w[i][j] = 8'($urandom);
        return w;
    endfunction

    function automatic win_row_t exp_row(input win_buf_t w, input int r);
        win_row_t res;
        for (int k = 0; k < WIN_DIM; k++) res[k] = w[r / 4][(r % 4) * 20 + k];
        return res;
    endfunction

    function automatic logic [31:0] exp_sum(input win_buf_t w);
        int s = 0;
        for (int i = 0; i < BUF_ROWS; i++)
            for (int j = 0; j < BUF_COLS; j++)
                s += int'(w[i][j]);
`ifdef HEU_WIN_SUM_EN
        return 32'(s);
`else
        return (s >= 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    function automatic logic [31:0] tag_obs();
        return 32'({bus.win_level, bus.win_row, bus.win_col});
    endfunction

    task automatic send(input win_buf_t w);
        int b = 0;
        bus.ipguOutBufferQ = w;
        bus.vldIpgu = 1'b1;
        while (!bus.rdyHeu && b < 100) begin
            tick();
            b++;
        end
        chk("send_rdy", 32'(bus.rdyHeu), 32'd1);
        tick();
        bus.vldIpgu = 1'b0;
    endtask

    task automatic drain(input win_buf_t w, input int tidx, input int start);
        bus.pix_rdy = 1'b1;
        for (int r = start; r < WIN_DIM; r++) begin
            chk("pix_vld", 32'(bus.pix_vld), 32'd1);
            chk("pix_row", 32'(bus.pix_row), 32'(r));
            chk_row("pix_out", bus.pix_out, exp_row(w, r));
            chk("pix_last", 32'(bus.pix_last), 32'(r == WIN_DIM - 1));
            if (r == start) chk("win_tag", tag_obs(), 32'(tag_of(tidx)));
            if (r == WIN_DIM - 1) chk("win_sum", 32'(bus.win_sum), exp_sum(w));
            tick();
        end
    endtask

    task automatic init_pulse();
        bus.initIpgu = 1'b1;
        tick();
        bus.initIpgu = 1'b0;
        chk("init_rdy_low", 32'(bus.rdyHeu), 32'd0);
        tick();
        chk("init_rdy_back", 32'(bus.rdyHeu), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        win_buf_t wa, wb, wc, wx, wy, wf;
        win_tag_t tq [$];
        int acc_n, cyc;

        rst_n = 1'b0;
        bus.initIpgu = 1'b0;
        bus.vldIpgu = 1'b0;
        bus.pix_rdy = 1'b0;
        bus.ipguOutBufferQ = '0;

        // Reset and idle
        #12;
        chk("rst_rdy", 32'(bus.rdyHeu), 32'd0);
        chk("rst_vld", 32'(bus.pix_vld), 32'd0);
        chk("rst_last", 32'(bus.pix_last), 32'd0);
        chk("rst_fdone", 32'(bus.frame_done), 32'd0);
        chk("rst_sum", 32'(bus.win_sum), 32'd0);
        chk("rst_row", 32'(bus.pix_row), 32'd0);
        chk("rst_tag", tag_obs(), 32'd0);
        chk_row("rst_pix", bus.pix_out, '0);
        rst_n = 1'b1;
        chk("rel_rdy_still0", 32'(bus.rdyHeu), 32'd0);
        tick();
        chk("rel_rdy", 32'(bus.rdyHeu), 32'd1);
        chk("rel_vld", 32'(bus.pix_vld), 32'd0);

        // Single window, consumer always ready
        wa = rand_win();
        bus.pix_rdy = 1'b1;
        send(wa);
        drain(wa, 0, 0);
        chk("single_empty", 32'(bus.pix_vld), 32'd0);

        // Back-to-back windows against a stalled consumer
        init_pulse();
        bus.pix_rdy = 1'b0;
        wa = rand_win();
        wb = rand_win();
        wc = rand_win();
        send(wa);
        send(wb);
        chk("full_rdy", 32'(bus.rdyHeu), 32'd0);
        bus.ipguOutBufferQ = wc;
        bus.vldIpgu = 1'b1;
        repeat (3) tick();
        chk("stall_rdy", 32'(bus.rdyHeu), 32'd0);
        chk("stall_row", 32'(bus.pix_row), 32'd0);
        chk_row("stall_pix", bus.pix_out, exp_row(wa, 0));
        drain(wa, 0, 0);
        chk("pop_rdy", 32'(bus.rdyHeu), 32'd1);
        tick();
        bus.vldIpgu = 1'b0;
        drain(wb, 1, 1);
        drain(wc, 2, 0);

        // Full image stream: tag sequence and frame_done
        init_pulse();
        bus.pix_rdy = 1'b1;
        bus.ipguOutBufferQ = rand_win();
        acc_n = 0;
        cyc = 0;
        while ((acc_n < 1806 || tq.size() != 0) && cyc < 60000) begin
            bit a_now, p_now;
            bus.vldIpgu = (acc_n < 1806);
            a_now = bus.vldIpgu && bus.rdyHeu;
            p_now = bus.pix_vld && bus.pix_last;
            if (bus.pix_vld && bus.pix_row == 5'd0)
                chk("stream_tag", tag_obs(), (tq.size() > 0) ? 32'(tq[0]) : 32'hFFFF_FFFF);
            tick();
            cyc++;
            if (a_now) begin
                tq.push_back(tag_of(acc_n));
                acc_n++;
            end
            if (p_now && tq.size() > 0) void'(tq.pop_front());
            chk("frame_done", 32'(bus.frame_done), 32'(a_now && acc_n == 1806));
        end
        bus.vldIpgu = 1'b0;
        chk("stream_count", 32'(acc_n), 32'd1806);
        chk("stream_drained", 32'(tq.size()), 32'd0);
        wa = rand_win();
        send(wa);
        drain(wa, 1806, 0);

        // initIpgu mid-window with a full buffer
        init_pulse();
        bus.pix_rdy = 1'b0;
        wa = rand_win();
        wb = rand_win();
        wx = rand_win();
        wy = rand_win();
        send(wa);
        send(wb);
        bus.pix_rdy = 1'b1;
        repeat (7) tick();
        chk("mid_beat", 32'(bus.pix_row), 32'd7);
        bus.ipguOutBufferQ = wx;
        bus.vldIpgu = 1'b1;
        bus.initIpgu = 1'b1;
        tick();
        bus.initIpgu = 1'b0;
        chk("init_vld", 32'(bus.pix_vld), 32'd0);
        chk("init_rdy", 32'(bus.rdyHeu), 32'd0);
        chk("init_fdone", 32'(bus.frame_done), 32'd0);
        chk("init_row", 32'(bus.pix_row), 32'd0);
        bus.ipguOutBufferQ = wy;
        tick();
        chk("init_no_accept", 32'(bus.pix_vld), 32'd0);
        chk("init_rdy_ret", 32'(bus.rdyHeu), 32'd1);
        tick();
        bus.vldIpgu = 1'b0;
        drain(wy, 0, 0);

        // Saturating pixel values for the window sum
        wf = '1;
        send(wf);
        drain(wf, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
